// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin front end that time-shares one external
// combinational multiplier among NREQ requesters. The winner's operands are
// registered, the product is captured one cycle later, and the result is
// returned on a single valid/ready response channel tagged with the winner's ID.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no operation in flight; any pending request may be granted
// S_EXEC | operands registered, multiplier settling; product captured
// S_RESP | product held on resp_*; a new grant may overlap the handshake
module dadda_mul_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WIDTH-1:0]    resp_prod,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      mul_in1,
  output logic [WIDTH-1:0]      mul_in2,
  input  logic [2*WIDTH-1:0]    mul_out,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     op_a_q;
  logic [WIDTH-1:0]     op_b_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CNTW-1:0]      cnt_q;

  logic [WIDTH-1:0]     a_arr [NREQ];
  logic [WIDTH-1:0]     b_arr [NREQ];
  logic [IDW-1:0]       cand;
  logic [IDW-1:0]       win_d;
  logic [IDW-1:0]       ptr_d;
  logic                 any_d;
  logic                 grant_cycle;
  logic                 grant_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_d = 1'b0;
    win_d = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(rr_ptr_q) + i) % NREQ);
      if (!any_d && req_valid[cand]) begin
        any_d = 1'b1;
        win_d = cand;
      end
    end
  end

  // A grant may overlap the response handshake to sustain one product per two cycles.
  assign grant_cycle = (state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready);
  assign grant_d     = grant_cycle && any_d;
  assign ptr_d       = (win_d == IDW'(NREQ - 1)) ? '0 : win_d + 1'b1;
  assign req_ready   = grant_d ? (NREQ'(1) << win_d) : '0;

  // Multiplier is fed only from registers, never straight from the request bus.
  assign mul_in1    = op_a_q;
  assign mul_in2    = op_b_q;
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_prod  = prod_q;
  assign resp_id    = id_q;
  assign op_count   = cnt_q;

  // Sequencer: grant/load operands, capture product, hold response until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_IDLE;
        S_EXEC: begin
          prod_q  <= mul_out;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A grant overrides the IDLE/RESP destination chosen above.
      if (grant_d) begin
        op_a_q   <= a_arr[win_d];
        op_b_q   <= b_arr[win_d];
        id_q     <= win_d;
        rr_ptr_q <= ptr_d;
        state_q  <= S_EXEC;
      end
    end
  end

endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
- Shares one combinational dadda_4 multiplier among NREQ requesters using round-robin arbitration.
- Registers the winner's operands, drives the shared multiplier, captures its product and returns it on a single valid/ready response channel tagged with the requester ID.
- Sits between client blocks and the multiplier instance, which is connected through the mul_* ports.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.
- NREQ, 4, number of requesters; must be at least 2.
- IDW, $clog2(NREQ), width of the requester ID.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant; combinational; at most one bit set.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_prod  out  2*WIDTH  product.
- resp_id  out  IDW  index of the requester that owns the product.
- mul_in1  out  WIDTH  operand A to the shared multiplier.
- mul_in2  out  WIDTH  operand B to the shared multiplier.
- mul_out  in  2*WIDTH  product from the shared multiplier; combinational, valid in the same cycle as its inputs.
- busy  out  1  high whenever the FSM is not IDLE.
- op_count  out  CNTW  number of completed responses.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, op_a=op_b=0, id_q=0, prod_q=0, op_count=0.
  - Outputs: resp_valid=0, req_ready=0, busy=0.
  - Reset mid-operation drops any in-flight or held result; no response is ever issued for it.
- Operand path: mul_in1=op_a and mul_in2=op_b at all times, taken directly from registers. The multiplier inputs never depend combinationally on req_*.
- Arbitration:
  - Scan req_valid starting at index rr_ptr, wrapping modulo NREQ. The first set bit wins.
  - A grant occurs only in a "grant cycle": state=IDLE, or state=RESP with resp_ready=1.
  - In a grant cycle with any req_valid set:
    - req_ready[w]=1 for the winner w;
    - op_a/op_b load req_a/req_b slice w; id_q loads w;
    - rr_ptr loads (w+1) mod NREQ; state goes to EXEC.
  - rr_ptr is unchanged when nothing is granted.
  - Requesters must hold req_valid and their operands until their req_ready bit is seen. Deasserting req_valid before the grant is legal; the request is then simply not served.
- FSM:
  - IDLE: busy=0, resp_valid=0. Grant -> EXEC; otherwise stay in IDLE.
  - EXEC: exactly one cycle. prod_q loads mul_out, then -> RESP. req_ready=0 in this state.
  - RESP: resp_valid=1, resp_prod=prod_q, resp_id=id_q.
    - resp_ready=0: hold; resp_prod and resp_id stay stable.
    - resp_ready=1: op_count increments, wrapping at 2^CNTW. Then grant -> EXEC, or no request -> IDLE.
- Timing:
  - Latency: request accepted at edge N -> resp_valid high in the cycle after edge N+1 (two cycles).
  - Peak throughput: one product every 2 cycles, achieved through the back-to-back grant in RESP.
- Arithmetic: unsigned, resp_prod = A*B, full 2*WIDTH bits, no overflow is possible.
- The multiplier's overflow signal is not used.

Test Plan:
1. After reset, requester 2 only, A=15, B=15, accepted at edge N -> resp_valid=1 at N+2 with resp_prod=225 and resp_id=2; resp_ready=1 -> op_count=1 and state IDLE.
2. All four req_valid held continuously, resp_ready=1 -> grants in order 0,1,2,3,0, one every 2 cycles; products match A*B; resp_id follows the same order.
3. Requesters 1 and 3 held, with rr_ptr=2 after an earlier grant to 1 -> grant 3, then 1, then 3.
4. A=9, B=7 with resp_ready=0 for 5 cycles -> resp_valid, resp_prod=63 and resp_id stay stable; no req_ready pulses; op_count unchanged until resp_ready=1.
5. rst=1 asserted during EXEC and again during RESP -> next cycle resp_valid=0, busy=0 and op_count=0; the dropped result is never emitted.
6. Exhaustive sweep: all 256 (A,B) pairs on requester 0 -> every resp_prod equals A*B; op_count=256.
